// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between NUM_M requesters.
// ARID is tagged with the requester index; R beats route back by that tag.
module axi_rd_arbiter #(
   parameter int NUM_M   = 2,
   parameter int IDX_W   = $clog2(NUM_M),
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int MAX_OUT = 8
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [NUM_M*ID_W-1:0]   S_ARID,
   input  logic [NUM_M*ADDR_W-1:0] S_ARADDR,
   input  logic [NUM_M*8-1:0]      S_ARLEN,
   input  logic [NUM_M*3-1:0]      S_ARSIZE,
   input  logic [NUM_M*2-1:0]      S_ARBURST,
   input  logic [NUM_M-1:0]        S_ARVALID,
   output logic [NUM_M-1:0]        S_ARREADY,
   output logic [NUM_M*ID_W-1:0]   S_RID,
   output logic [NUM_M*DATA_W-1:0] S_RDATA,
   output logic [NUM_M*2-1:0]      S_RRESP,
   output logic [NUM_M-1:0]        S_RLAST,
   output logic [NUM_M-1:0]        S_RVALID,
   input  logic [NUM_M-1:0]        S_RREADY,
   output logic [IDX_W+ID_W-1:0]   M_ARID,
   output logic [ADDR_W-1:0]       M_ARADDR,
   output logic [7:0]              M_ARLEN,
   output logic [2:0]              M_ARSIZE,
   output logic [1:0]              M_ARBURST,
   output logic                    M_ARVALID,
   input  logic                    M_ARREADY,
   input  logic [IDX_W+ID_W-1:0]   M_RID,
   input  logic [DATA_W-1:0]       M_RDATA,
   input  logic [1:0]              M_RRESP,
   input  logic                    M_RLAST,
   input  logic                    M_RVALID,
   output logic                    M_RREADY,
   output logic                    ERR_UNDERFLOW
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] g_q, g_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] r_idx;
   logic [7:0]       cnt_q [NUM_M];
   logic [7:0]       cnt_d [NUM_M];
   logic             err_q, err_d;
   logic             ar_hs, r_done;
   logic [NUM_M-1:0] elig, inc_v, dec_v;
   logic [NUM_M-1:0] one_v;

   assign one_v = {{(NUM_M-1){1'b0}}, 1'b1};
   assign r_idx = M_RID[IDX_W+ID_W-1:ID_W];

   always_comb begin
      for (int i = 0; i < NUM_M; i++)
         elig[i] = S_ARVALID[i] && (cnt_q[i] != 8'(MAX_OUT));
   end

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      last_d  = last_q;
      cand    = '0;
      ar_hs   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Descending walk so the nearest index after last_q wins.
            for (int k = NUM_M; k >= 1; k--) begin
               cand = last_q + IDX_W'(k);
               if (elig[cand]) begin
                  g_d     = cand;
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (M_ARREADY) begin
               ar_hs   = 1'b1;
               last_d  = g_q;
               state_d = IDLE;
            end
         end
      endcase
   end

   assign M_ARVALID = !ARESET && (state_q == LOCKED);
   assign S_ARREADY = M_ARVALID ? ({{(NUM_M-1){1'b0}}, M_ARREADY} << g_q) : '0;
   assign M_ARID    = {g_q, S_ARID[g_q*ID_W +: ID_W]};
   assign M_ARADDR  = S_ARADDR[g_q*ADDR_W +: ADDR_W];
   assign M_ARLEN   = S_ARLEN[g_q*8 +: 8];
   assign M_ARSIZE  = S_ARSIZE[g_q*3 +: 3];
   assign M_ARBURST = S_ARBURST[g_q*2 +: 2];

   assign S_RVALID = ARESET ? '0 : ({{(NUM_M-1){1'b0}}, M_RVALID} << r_idx);
   assign M_RREADY = !ARESET && S_RREADY[r_idx];
   assign S_RID    = {NUM_M{M_RID[ID_W-1:0]}};
   assign S_RDATA  = {NUM_M{M_RDATA}};
   assign S_RRESP  = {NUM_M{M_RRESP}};
   assign S_RLAST  = {NUM_M{M_RLAST}};
   assign r_done   = M_RVALID && M_RREADY && M_RLAST;

   assign inc_v = ar_hs  ? (one_v << g_q)   : '0;
   assign dec_v = r_done ? (one_v << r_idx) : '0;

   always_comb begin
      err_d = err_q;
      for (int i = 0; i < NUM_M; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc_v[i] && !dec_v[i]) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end else if (dec_v[i] && !inc_v[i]) begin
            if (cnt_q[i] == 8'd0) err_d = 1'b1;
            else cnt_d[i] = cnt_q[i] - 8'd1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         g_q     <= '0;
         last_q  <= IDX_W'(NUM_M - 1);
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_M; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         last_q  <= last_d;
         err_q   <= err_d;
         for (int i = 0; i < NUM_M; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign ERR_UNDERFLOW = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of grants and outstanding counts.
module tb_axi_rd_arbiter;
   localparam int NM = 2, IW = 4, AW = 32, DW = 64, MO = 2;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [7:0]    S_ARID;
   logic [63:0]   S_ARADDR;
   logic [15:0]   S_ARLEN;
   logic [5:0]    S_ARSIZE;
   logic [3:0]    S_ARBURST;
   logic [1:0]    S_ARVALID, S_ARREADY;
   logic [7:0]    S_RID;
   logic [127:0]  S_RDATA;
   logic [3:0]    S_RRESP;
   logic [1:0]    S_RLAST, S_RVALID, S_RREADY;
   logic [4:0]    M_ARID;
   logic [31:0]   M_ARADDR;
   logic [7:0]    M_ARLEN;
   logic [2:0]    M_ARSIZE;
   logic [1:0]    M_ARBURST;
   logic          M_ARVALID, M_ARREADY;
   logic [4:0]    M_RID;
   logic [63:0]   M_RDATA;
   logic [1:0]    M_RRESP;
   logic          M_RLAST, M_RVALID, M_RREADY;
   logic          ERR_UNDERFLOW;

   axi_rd_arbiter #(
      .NUM_M(NM), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
      .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
      .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
      .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
      .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
      .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
      .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
      .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
      .M_RLAST(M_RLAST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
      .ERR_UNDERFLOW(ERR_UNDERFLOW)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int failures = 0;

   // Model: owner = requester holding the AR grant (-1 none).
   int   mcnt [2];
   int   mlast;
   int   mown;
   bit   merr;
   logic [3:0]  qid [2];
   logic [31:0] qaddr [2];
   logic [7:0]  qlen [2];

   task automatic set_req(input int i, input logic [3:0] id,
                          input logic [31:0] a, input logic [7:0] l);
      qid[i] = id;
      qaddr[i] = a;
      qlen[i] = l;
      S_ARID[i*4 +: 4] = id;
      S_ARADDR[i*32 +: 32] = a;
      S_ARLEN[i*8 +: 8] = l;
      S_ARSIZE[i*3 +: 3] = 3'd3;
      S_ARBURST[i*2 +: 2] = 2'd1;
   endtask

   task automatic tick();
      int  r, nown, c;
      bit  arhs, rl, inc, dec, found;
      r = int'(M_RID[4]);
      arhs = !ARESET && mown >= 0 && M_ARREADY;
      rl = !ARESET && M_RVALID && S_RREADY[r] && M_RLAST;
      if (ARESET) begin
         mown = -1;
         mlast = 1;
         merr = 0;
         mcnt[0] = 0;
         mcnt[1] = 0;
      end else begin
         nown = mown;
         if (mown < 0) begin
            found = 0;
            for (int k = 1; k <= 2; k++) begin
               c = (mlast + k) % 2;
               if (!found && S_ARVALID[c] && mcnt[c] != MO) begin
                  nown = c;
                  found = 1;
               end
            end
         end else if (arhs) begin
            mlast = mown;
            nown = -1;
         end
         for (int i = 0; i < 2; i++) begin
            inc = arhs && mown == i;
            dec = rl && r == i;
            if (inc && !dec) mcnt[i]++;
            if (dec && !inc) begin
               if (mcnt[i] == 0) merr = 1;
               else mcnt[i]--;
            end
         end
         mown = nown;
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      ARESET = 1;
      S_ARVALID = 0;
      M_RVALID = 0;
      M_RLAST = 0;
      M_ARREADY = 0;
      tick();
      ARESET = 0;
   endtask

   task automatic test_reset();
      ARESET = 1;
      S_ARVALID = 2'b11;
      M_ARREADY = 1;
      M_RVALID = 1;
      M_RLAST = 0;
      M_RID = 5'h10;
      S_RREADY = 2'b11;
      #1;
      checks++;
      if (M_ARVALID !== 1'b0) begin
         failures++;
         $display("FAIL rst_arvalid got=%b want=0", M_ARVALID);
      end
      checks++;
      if (S_ARREADY !== 2'b00) begin
         failures++;
         $display("FAIL rst_arready got=%b want=00", S_ARREADY);
      end
      checks++;
      if (S_RVALID !== 2'b00 || M_RREADY !== 1'b0) begin
         failures++;
         $display("FAIL rst_r got=%b/%b want=00/0", S_RVALID, M_RREADY);
      end
      tick();
      S_ARVALID = 0;
      M_RVALID = 0;
      M_ARREADY = 0;
      ARESET = 0;
      #1;
      checks++;
      if (ERR_UNDERFLOW !== 1'b0 || M_ARVALID !== 1'b0) begin
         failures++;
         $display("FAIL rst_state got=%b/%b want=0/0",
                  ERR_UNDERFLOW, M_ARVALID);
      end
   endtask

   task automatic test_single();
      logic [63:0] d;
      int g;
      set_req(0, 4'h3, 32'h100, 8'd3);
      S_ARVALID = 2'b01;
      M_ARREADY = 1;
      #1;
      checks++;
      if (M_ARVALID !== 1'b0) begin
         failures++;
         $display("FAIL single_idle got=%b want=0", M_ARVALID);
      end
      tick();
      checks++;
      if (M_ARVALID !== 1'b1 || M_ARID !== 5'h03) begin
         failures++;
         $display("FAIL single_ar got=%b/%h want=1/03", M_ARVALID, M_ARID);
      end
      checks++;
      if (M_ARADDR !== 32'h100 || M_ARLEN !== 8'd3 ||
          S_ARREADY !== 2'b01) begin
         failures++;
         $display("FAIL single_fields got=%h/%h/%b want=100/03/01",
                  M_ARADDR, M_ARLEN, S_ARREADY);
      end
      tick();
      S_ARVALID = 0;
      for (int b = 0; b < 4; b++) begin
         d = {$urandom, $urandom};
         M_RVALID = 1;
         M_RID = 5'h03;
         M_RLAST = (b == 3);
         M_RDATA = d;
         M_RRESP = 2'b00;
         S_RREADY = 2'b01;
         #1;
         checks++;
         if (S_RVALID !== 2'b01 || S_RLAST[0] !== (b == 3) ||
             S_RDATA[63:0] !== d || S_RID[3:0] !== 4'h3 ||
             M_RREADY !== 1'b1) begin
            failures++;
            $display("FAIL single_r%0d got=%b/%b/%h want=01/%b/%h",
                     b, S_RVALID, S_RLAST[0], S_RDATA[63:0], b == 3, d);
         end
         tick();
      end
      M_RVALID = 0;
      M_RLAST = 0;
      S_ARVALID = 2'b01;
      g = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         g += int'(M_ARVALID);
         tick();
      end
      S_ARVALID = 0;
      checks++;
      if (g != 2) begin
         failures++;
         $display("FAIL single_cnt_back_to_0 got=%0d want=2 grants", g);
      end
   endtask

   task automatic test_alternate();
      bit ev;
      int idx;
      do_reset();
      set_req(0, 4'hA, 32'h1000, 8'd0);
      set_req(1, 4'h5, 32'h2000, 8'd1);
      S_ARVALID = 2'b11;
      M_ARREADY = 1;
      for (int c = 0; c < 10; c++) begin
         #1;
         ev = (c % 2 == 1) && c < 8;
         idx = (c / 2) % 2;
         checks++;
         if (M_ARVALID !== ev) begin
            failures++;
            $display("FAIL alt_valid c%0d got=%b want=%b", c, M_ARVALID, ev);
         end
         if (ev) begin
            checks++;
            if (M_ARID !== {idx[0], qid[idx]}) begin
               failures++;
               $display("FAIL alt_id c%0d got=%h want=%h",
                        c, M_ARID, {idx[0], qid[idx]});
            end
         end
         tick();
      end
      S_ARVALID = 0;
      for (int j = 0; j < 4; j++) begin
         M_RVALID = 1;
         M_RLAST = 1;
         M_RID = {j[0], 4'h0};
         S_RREADY = 2'b11;
         tick();
      end
      M_RVALID = 0;
      M_RLAST = 0;
      #1;
      checks++;
      if (ERR_UNDERFLOW !== 1'b0) begin
         failures++;
         $display("FAIL alt_drain_err got=%b want=0", ERR_UNDERFLOW);
      end
   endtask

   task automatic test_stall();
      do_reset();
      set_req(0, 4'h1, 32'h300, 8'd2);
      set_req(1, 4'h9, 32'h400, 8'd7);
      S_ARVALID = 2'b10;
      M_ARREADY = 0;
      tick();
      S_ARVALID = 2'b11;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (M_ARVALID !== 1'b1 || M_ARID !== 5'h19 ||
             M_ARADDR !== 32'h400 || M_ARLEN !== 8'd7 ||
             S_ARREADY !== 2'b00) begin
            failures++;
            $display("FAIL stall_hold c%0d got=%b/%h/%h/%b want=1/19/400/00",
                     c, M_ARVALID, M_ARID, M_ARADDR, S_ARREADY);
         end
         tick();
      end
      M_ARREADY = 1;
      #1;
      checks++;
      if (S_ARREADY !== 2'b10) begin
         failures++;
         $display("FAIL stall_ready got=%b want=10", S_ARREADY);
      end
      tick();
      S_ARVALID = 2'b01;
      #1;
      checks++;
      if (M_ARVALID !== 1'b0) begin
         failures++;
         $display("FAIL stall_idle got=%b want=0", M_ARVALID);
      end
      tick();
      checks++;
      if (M_ARVALID !== 1'b1 || M_ARID !== 5'h01 || S_ARREADY !== 2'b01) begin
         failures++;
         $display("FAIL stall_req0 got=%b/%h/%b want=1/01/01",
                  M_ARVALID, M_ARID, S_ARREADY);
      end
      tick();
      S_ARVALID = 0;
   endtask

   task automatic test_maxout();
      do_reset();
      set_req(0, 4'h2, 32'h500, 8'd0);
      set_req(1, 4'h6, 32'h600, 8'd0);
      S_ARVALID = 2'b01;
      M_ARREADY = 1;
      for (int c = 0; c < 4; c++) tick();
      S_ARVALID = 2'b11;
      #1;
      checks++;
      if (M_ARVALID !== 1'b0) begin
         failures++;
         $display("FAIL max_idle got=%b want=0", M_ARVALID);
      end
      tick();
      checks++;
      if (M_ARVALID !== 1'b1 || M_ARID !== 5'h16) begin
         failures++;
         $display("FAIL max_req1 got=%b/%h want=1/16", M_ARVALID, M_ARID);
      end
      tick();
      S_ARVALID = 2'b01;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (M_ARVALID !== 1'b0) begin
            failures++;
            $display("FAIL max_full c%0d got=%b want=0", c, M_ARVALID);
         end
         if (c == 0) tick();
      end
      M_RVALID = 1;
      M_RLAST = 1;
      M_RID = 5'h02;
      S_RREADY = 2'b01;
      tick();
      M_RVALID = 0;
      M_RLAST = 0;
      #1;
      checks++;
      if (M_ARVALID !== 1'b0) begin
         failures++;
         $display("FAIL max_regrant_idle got=%b want=0", M_ARVALID);
      end
      tick();
      checks++;
      if (M_ARVALID !== 1'b1 || M_ARID !== 5'h02) begin
         failures++;
         $display("FAIL max_regrant got=%b/%h want=1/02", M_ARVALID, M_ARID);
      end
      tick();
      S_ARVALID = 0;
   endtask

   task automatic test_interleave_r();
      M_RVALID = 1;
      M_RLAST = 0;
      M_RID = 5'h15;
      S_RREADY = 2'b11;
      #1;
      checks++;
      if (S_RVALID !== 2'b10 || S_RID[7:4] !== 4'h5 || M_RREADY !== 1'b1) begin
         failures++;
         $display("FAIL rint_req1 got=%b/%h/%b want=10/5/1",
                  S_RVALID, S_RID[7:4], M_RREADY);
      end
      tick();
      M_RID = 5'h02;
      #1;
      checks++;
      if (S_RVALID !== 2'b01 || S_RID[3:0] !== 4'h2) begin
         failures++;
         $display("FAIL rint_req0 got=%b/%h want=01/2", S_RVALID, S_RID[3:0]);
      end
      tick();
      M_RID = 5'h15;
      S_RREADY = 2'b01;
      #1;
      checks++;
      if (M_RREADY !== 1'b0 || S_RVALID !== 2'b10) begin
         failures++;
         $display("FAIL rint_stall got=%b/%b want=0/10", M_RREADY, S_RVALID);
      end
      tick();
      M_RVALID = 0;
   endtask

   task automatic test_underflow();
      do_reset();
      M_RID = 5'h10;
      M_RVALID = 1;
      M_RLAST = 1;
      S_RREADY = 2'b11;
      #1;
      checks++;
      if (ERR_UNDERFLOW !== 1'b0) begin
         failures++;
         $display("FAIL uf_before got=%b want=0", ERR_UNDERFLOW);
      end
      tick();
      M_RVALID = 0;
      M_RLAST = 0;
      #1;
      checks++;
      if (ERR_UNDERFLOW !== 1'b1) begin
         failures++;
         $display("FAIL uf_set got=%b want=1", ERR_UNDERFLOW);
      end
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (ERR_UNDERFLOW !== 1'b1) begin
         failures++;
         $display("FAIL uf_sticky got=%b want=1", ERR_UNDERFLOW);
      end
      set_req(0, 4'h4, 32'h700, 8'd0);
      S_ARVALID = 2'b01;
      M_ARREADY = 0;
      tick();
      checks++;
      if (M_ARVALID !== 1'b1) begin
         failures++;
         $display("FAIL uf_locked got=%b want=1", M_ARVALID);
      end
      ARESET = 1;
      #1;
      checks++;
      if (M_ARVALID !== 1'b0 || S_ARREADY !== 2'b00) begin
         failures++;
         $display("FAIL uf_rst_force got=%b/%b want=0/00",
                  M_ARVALID, S_ARREADY);
      end
      tick();
      ARESET = 0;
      S_ARVALID = 0;
      #1;
      checks++;
      if (ERR_UNDERFLOW !== 1'b0 || M_ARVALID !== 1'b0) begin
         failures++;
         $display("FAIL uf_cleared got=%b/%b want=0/0",
                  ERR_UNDERFLOW, M_ARVALID);
      end
   endtask

   task automatic test_random();
      int r, ho;
      bit hs;
      logic [1:0] ear, erv;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!S_ARVALID[i] && $urandom_range(3, 0) == 0) begin
               set_req(i, 4'($urandom), $urandom, 8'($urandom));
               S_ARVALID[i] = 1'b1;
            end
         end
         M_ARREADY = ($urandom_range(2, 0) != 0);
         r = $urandom_range(1, 0);
         M_RVALID = ($urandom_range(1, 0) == 1);
         M_RID = {r[0], 4'($urandom)};
         M_RLAST = (mcnt[r] > 0) && ($urandom_range(1, 0) == 1);
         M_RDATA = {$urandom, $urandom};
         M_RRESP = 2'($urandom);
         S_RREADY = 2'($urandom);
         #1;
         ear = (mown >= 0 && M_ARREADY) ? (2'b01 << mown) : 2'b00;
         erv = M_RVALID ? (2'b01 << r) : 2'b00;
         checks++;
         if (M_ARVALID !== (mown >= 0)) begin
            failures++;
            $display("FAIL rnd_arvalid c%0d got=%b want=%b",
                     c, M_ARVALID, mown >= 0);
         end
         if (mown >= 0) begin
            checks++;
            if (M_ARID !== {mown[0], qid[mown]} ||
                M_ARADDR !== qaddr[mown] || M_ARLEN !== qlen[mown]) begin
               failures++;
               $display("FAIL rnd_fields c%0d got=%h/%h want=%h/%h",
                        c, M_ARID, M_ARADDR, {mown[0], qid[mown]},
                        qaddr[mown]);
            end
         end
         checks++;
         if (S_ARREADY !== ear) begin
            failures++;
            $display("FAIL rnd_arready c%0d got=%b want=%b", c, S_ARREADY, ear);
         end
         checks++;
         if (S_RVALID !== erv || M_RREADY !== S_RREADY[r]) begin
            failures++;
            $display("FAIL rnd_r c%0d got=%b/%b want=%b/%b",
                     c, S_RVALID, M_RREADY, erv, S_RREADY[r]);
         end
         checks++;
         if (ERR_UNDERFLOW !== merr) begin
            failures++;
            $display("FAIL rnd_err c%0d got=%b want=%b",
                     c, ERR_UNDERFLOW, merr);
         end
         hs = mown >= 0 && M_ARREADY;
         ho = mown;
         tick();
         if (hs) S_ARVALID[ho] = 1'b0;
      end
      S_ARVALID = 0;
      M_RVALID = 0;
   endtask

   initial begin
      ARESET = 1;
      S_ARID = '0;
      S_ARADDR = '0;
      S_ARLEN = '0;
      S_ARSIZE = '0;
      S_ARBURST = '0;
      S_ARVALID = '0;
      S_RREADY = '0;
      M_ARREADY = 0;
      M_RID = '0;
      M_RDATA = '0;
      M_RRESP = '0;
      M_RLAST = 0;
      M_RVALID = 0;
      mown = -1;
      mlast = 1;
      merr = 0;
      mcnt[0] = 0;
      mcnt[1] = 0;
      for (int i = 0; i < 2; i++) begin
         qid[i] = '0;
         qaddr[i] = '0;
         qlen[i] = '0;
      end
      test_reset();
      test_single();
      test_alternate();
      test_stall();
      test_maxout();
      test_interleave_r();
      test_underflow();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Round-robin arbiter sharing one downstream AXI4 read port (AR + R channels) between NUM_M upstream requesters.
- Tags each forwarded ARID with the requester index and routes R beats back by that index.
- Limits outstanding bursts per requester.
- Sits between VIP-driven or RTL masters and a single slave/interconnect port.

Parameters:
- NUM_M, 2, number of requesters; power of two, 2..8.
- IDX_W, $clog2(NUM_M), requester index width (derived).
- ID_W, 4, upstream ID width.
- ADDR_W, 32, address width.
- DATA_W, 64, data width.
- MAX_OUT, 8, max outstanding AR bursts per requester (1..255).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- S_ARID  in  NUM_M*ID_W  per-requester ARID, packed, requester 0 in LSBs (same packing for all S_ vectors).
- S_ARADDR  in  NUM_M*ADDR_W  per-requester ARADDR.
- S_ARLEN  in  NUM_M*8  per-requester ARLEN.
- S_ARSIZE  in  NUM_M*3  per-requester ARSIZE.
- S_ARBURST  in  NUM_M*2  per-requester ARBURST.
- S_ARVALID  in  NUM_M  per-requester ARVALID.
- S_ARREADY  out  NUM_M  per-requester ARREADY.
- S_RID  out  NUM_M*ID_W  RID, upstream width.
- S_RDATA  out  NUM_M*DATA_W  RDATA.
- S_RRESP  out  NUM_M*2  RRESP.
- S_RLAST  out  NUM_M  RLAST.
- S_RVALID  out  NUM_M  RVALID.
- S_RREADY  in  NUM_M  RREADY.
- M_ARID  out  IDX_W+ID_W  {requester index, upstream ARID}.
- M_ARADDR  out  ADDR_W  ARADDR.
- M_ARLEN  out  8  ARLEN.
- M_ARSIZE  out  3  ARSIZE.
- M_ARBURST  out  2  ARBURST.
- M_ARVALID  out  1  ARVALID.
- M_ARREADY  in  1  ARREADY.
- M_RID  in  IDX_W+ID_W  RID.
- M_RDATA  in  DATA_W  RDATA.
- M_RRESP  in  2  RRESP.
- M_RLAST  in  1  RLAST.
- M_RVALID  in  1  RVALID.
- M_RREADY  out  1  RREADY.
- ERR_UNDERFLOW  out  1  sticky flag: RLAST received for a requester with zero outstanding bursts.

Behaviour:
- Reset (ARESET=1 at posedge):
  - FSM to IDLE, last_grant = NUM_M-1.
  - All outstanding counters 0, ERR_UNDERFLOW 0.
- While ARESET=1, the following are forced to 0 combinationally: M_ARVALID, S_ARREADY, S_RVALID, M_RREADY.
- FSM IDLE:
  - eligible[i] = S_ARVALID[i] && cnt[i] != MAX_OUT.
  - If eligible is nonzero, grant the first eligible index searching upward from last_grant+1 (mod NUM_M), register it as g, and go to LOCKED.
  - M_ARVALID=0 in IDLE.
- FSM LOCKED:
  - M_ARVALID=1; M_AR* = requester g's fields; M_ARID = {g, S_ARID[g]}.
  - S_ARREADY[g] = M_ARREADY; all other S_ARREADY = 0.
  - On M_ARREADY=1: cnt[g]++, last_grant = g, next state IDLE.
  - Grant is held until handshake; the requester must keep ARVALID and its fields stable (AXI rule). No deassertion is tolerated.
- AR latency: S_ARVALID rising in IDLE gives M_ARVALID one cycle later. Maximum AR throughput is one burst per 2 cycles.
- R path (combinational, zero latency):
  - r = M_RID[IDX_W+ID_W-1:ID_W].
  - S_RVALID[r] = M_RVALID; other S_RVALID = 0.
  - S_RDATA/S_RRESP/S_RLAST/S_RID of every requester = M_RDATA/M_RRESP/M_RLAST/M_RID[ID_W-1:0] (broadcast; qualified by S_RVALID).
  - M_RREADY = S_RREADY[r].
- Counters (8-bit):
  - Decrement cnt[r] on M_RVALID && M_RREADY && M_RLAST.
  - Simultaneous increment and decrement on the same requester leaves cnt unchanged.
  - Decrement when cnt[r]==0: cnt stays 0 and ERR_UNDERFLOW is set. It clears only on reset.
- Full requester (cnt==MAX_OUT) is skipped by arbitration. It becomes eligible again the cycle after its count drops.
- Reset mid-burst: state is discarded and in-flight R beats are not tracked. The integrator must reset the downstream slave together with this block.

Test Plan:
- NUM_M=2; only req0 sends ARID=3, ADDR=0x100, LEN=3 -> M_ARVALID one cycle later with M_ARID=0x03; after 4 R beats with RID=0x03, req0 sees 4 S_RVALID beats with RLAST on the 4th, and cnt0 returns 0.
- Both requesters hold ARVALID continuously and M_ARREADY=1 -> grants alternate 0,1,0,1; M_ARID MSB toggles; one AR every 2 cycles.
- M_ARREADY=0 for 5 cycles while LOCKED on req1 -> M_ARVALID stays 1 with stable fields; S_ARREADY=00; req0 is not granted until the req1 handshake completes.
- MAX_OUT=2; req0 issues 2 ARs with no R returned -> third req0 AR is stalled while req1 is still granted; one RLAST to req0 -> req0 is granted on the next IDLE cycle.
- Interleaved R: RID=0x15 then 0x02 with M_RREADY gated by S_RREADY -> beats go to req1 then req0; S_RREADY[1]=0 stalls M_RREADY.
- Inject RLAST with RID MSB=1 while cnt1=0 -> ERR_UNDERFLOW=1 and stays 1; ARESET pulse clears it and forces M_ARVALID=0 the same cycle.
